beat_sequencer: RTL and testbench
=================================

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 The module SHALL have parameter TICK_DIV, default 25_000_000, meaning the number of clk cycles per beat at normal tempo.
REQ-002 The module SHALL have parameter LAST_BEAT, default 63, meaning the final beat index of the pattern.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have port clk, input, 1 bit: the system clock, with all logic on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The module SHALL have port play_de, input, 1 bit: debounced one-pulse play/pause request.
REQ-007 The module SHALL have port stop_de, input, 1 bit: debounced one-pulse stop request.
REQ-008 The module SHALL have port tempo_sel, input, 2 bits: 0 selects TICK_DIV, 1 selects TICK_DIV/2 (fast), 2 selects TICK_DIV*2 (slow), 3 behaves as 0.
REQ-009 The module SHALL have port ibeatNum, output, 12 bits: current beat index, fed to beat-indexed consumers.
REQ-010 The module SHALL have port beat_tick, output, 1 bit: one-cycle pulse in the cycle ibeatNum takes a new value.
REQ-011 The module SHALL have port playing, output, 1 bit: high while in state PLAY.
REQ-012 The module SHALL have port done, output, 1 bit: high while in state DONE.

Function
REQ-013 The module SHALL implement states IDLE, PLAY, PAUSE and DONE, with all outputs registered.
REQ-014 A play_de pulse in IDLE SHALL enter PLAY with ibeatNum=0 and the prescaler at 0; playing SHALL rise the next cycle.
REQ-015 In PLAY, the prescaler SHALL increment each cycle; on reaching divisor-1 it SHALL clear, ibeatNum SHALL increment, and beat_tick SHALL pulse.
REQ-016 The first beat_tick SHALL occur exactly divisor cycles after playing rises, and subsequent ticks every divisor cycles.
REQ-017 A play_de pulse in PLAY SHALL enter PAUSE; the prescaler and ibeatNum SHALL be held, and no tick SHALL occur.
REQ-018 A play_de pulse in PAUSE SHALL return to PLAY, resuming from the held prescaler value.
REQ-019 A play_de pulse in DONE SHALL enter PLAY restarting from ibeatNum=0 with the prescaler at 0.
REQ-020 A stop_de pulse in any state SHALL enter IDLE with ibeatNum=0, the prescaler at 0, and beat_tick=0.
REQ-021 When play_de and stop_de arrive in the same cycle, stop_de SHALL win.
REQ-022 When stop_de coincides with a terminal prescaler count, stop_de SHALL win and no tick SHALL be issued.
REQ-023 A tempo_sel change SHALL take effect immediately; if prescaler >= new divisor-1, the tick SHALL fire on the next cycle and the prescaler SHALL clear.
REQ-024 Prescaler width SHALL be 32 bits, and divisors SHALL be computed by integer arithmetic with TICK_DIV/2 truncated.
REQ-025 ibeatNum SHALL never exceed LAST_BEAT.

Reset
REQ-026 On rst=1 at a clk edge, the module SHALL set state=IDLE, ibeatNum=0, prescaler=0, beat_tick=0, playing=0 and done=0.
REQ-027 Reset SHALL take priority over play_de, stop_de and any pending tick, including mid-beat and in PAUSE.

Configuration
REQ-028 Macro BEAT_SEQUENCER_LOOP_EN SHALL select the end-of-pattern behaviour.
REQ-029 With BEAT_SEQUENCER_LOOP_EN defined, the tick following ibeatNum=LAST_BEAT SHALL wrap ibeatNum to 0 with beat_tick pulsed, remaining in PLAY, and done SHALL never assert.
REQ-030 Without BEAT_SEQUENCER_LOOP_EN, the tick following ibeatNum=LAST_BEAT SHALL enter DONE with ibeatNum held at LAST_BEAT, no beat_tick, playing=0 and done=1.

Verification (TICK_DIV=4, LAST_BEAT=7)
REQ-031 The bench SHALL cover: rst then play_de at cycle 10 -> playing=1 at cycle 11, ticks at cycles 15, 19, 23 with ibeatNum 1, 2, 3.
REQ-032 The bench SHALL cover: play_de pulse 2 cycles after a tick, hold 20 cycles, then play_de again -> ibeatNum frozen during pause, next tick 2 cycles after resume.
REQ-033 The bench SHALL cover: tempo_sel 0->1 with prescaler=3 -> tick on the next cycle, then every 2 cycles.
REQ-034 The bench SHALL cover: run to ibeatNum=7 -> without the macro, done=1, ibeatNum=7, no further ticks; with the macro, ibeatNum=0 with beat_tick and playing=1.
REQ-035 The bench SHALL cover: play_de and stop_de in the same cycle while in PLAY at ibeatNum=5 -> IDLE, ibeatNum=0, playing=0.
REQ-036 The bench SHALL cover: rst asserted in PAUSE at ibeatNum=4 -> all outputs 0 the next cycle; play_de then restarts from beat 0.

Source files
------------

// File: rtl/beat_sequencer.sv
// Beat sequencer: a play/pause/stop FSM that steps a beat index at a selectable tempo.
// Define BEAT_SEQUENCER_LOOP_EN to wrap to beat 0 at the end of the pattern instead of stopping in DONE.
module beat_sequencer #(
   parameter int TICK_DIV  = 25_000_000,
   parameter int LAST_BEAT = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        play_de,
   input  logic        stop_de,
   input  logic [1:0]  tempo_sel,
   output logic [11:0] ibeatNum,
   output logic        beat_tick,
   output logic        playing,
   output logic        done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PLAY  = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [31:0] DIV_NORM = 32'(TICK_DIV);
   localparam logic [31:0] DIV_FAST = 32'(TICK_DIV / 2);
   localparam logic [31:0] DIV_SLOW = 32'(TICK_DIV * 2);
   localparam logic [11:0] LAST     = 12'(LAST_BEAT);

   logic [1:0]  state_reg, state_next;
   logic [31:0] presc_reg, presc_next;
   logic [11:0] beat_reg, beat_next;
   logic        tick_reg, tick_next;
   logic        playing_reg, done_reg;
   logic [31:0] divisor;
   logic        terminal;

   always_comb begin
      case (tempo_sel)
         2'd1:    divisor = DIV_FAST;
         2'd2:    divisor = DIV_SLOW;
         default: divisor = DIV_NORM;
      endcase
   end

   // Using >= lets a tempo switch to a shorter beat fire straight away when the
   // count is already past the new end; divisors of 0 or 1 tick every cycle.
   assign terminal = (divisor <= 32'd1) ? 1'b1 : (presc_reg >= divisor - 32'd1);

   always_comb begin
      state_next = state_reg;
      presc_next = presc_reg;
      beat_next  = beat_reg;
      tick_next  = 1'b0;
      if (stop_de) begin
         state_next = IDLE;
         presc_next = '0;
         beat_next  = '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (play_de) begin
                  state_next = PLAY;
                  presc_next = '0;
                  beat_next  = '0;
               end
            end
            PLAY: begin
               if (play_de) begin
                  state_next = PAUSE;
               end else if (terminal) begin
                  presc_next = '0;
                  if (beat_reg >= LAST) begin
`ifdef BEAT_SEQUENCER_LOOP_EN
                     beat_next = '0;
                     tick_next = 1'b1;
`else
                     state_next = DONE;
`endif
                  end else begin
                     beat_next = beat_reg + 12'd1;
                     tick_next = 1'b1;
                  end
               end else begin
                  presc_next = presc_reg + 32'd1;
               end
            end
            PAUSE: begin
               if (play_de) state_next = PLAY;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         presc_reg   <= '0;
         beat_reg    <= '0;
         tick_reg    <= 1'b0;
         playing_reg <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         presc_reg   <= presc_next;
         beat_reg    <= beat_next;
         tick_reg    <= tick_next;
         playing_reg <= (state_next == PLAY);
         done_reg    <= (state_next == DONE);
      end
   end

   assign ibeatNum  = beat_reg;
   assign beat_tick = tick_reg;
   assign playing   = playing_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer (TICK_DIV=4, LAST_BEAT=7): directed scenarios, then random
// stimulus, all checked every cycle against a beat-level reference model.
module tb_beat_sequencer;

   localparam int TICK_DIV  = 4;
   localparam int LAST_BEAT = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        play_de = 1'b0;
   logic        stop_de = 1'b0;
   logic [1:0]  tempo_sel = 2'd0;
   logic [11:0] ibeatNum;
   logic        beat_tick;
   logic        playing;
   logic        done;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0 idle, 1 play, 2 pause, 3 done; elapsed = cycles spent in current beat.
   int m_mode = 0;
   int m_elapsed = 0;
   int m_beat = 0;
   int m_tick = 0;

   beat_sequencer #(.TICK_DIV(TICK_DIV), .LAST_BEAT(LAST_BEAT)) dut (
      .clk(clk), .rst(rst), .play_de(play_de), .stop_de(stop_de),
      .tempo_sel(tempo_sel), .ibeatNum(ibeatNum), .beat_tick(beat_tick),
      .playing(playing), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int beat_len(input int sel);
      if (sel == 1) return TICK_DIV / 2;
      if (sel == 2) return TICK_DIV * 2;
      return TICK_DIV;
   endfunction

   task automatic model_update();
      m_tick = 0;
      if (rst || stop_de) begin
         m_mode = 0; m_elapsed = 0; m_beat = 0;
      end else if (m_mode == 1) begin
         if (play_de) m_mode = 2;
         else if (m_elapsed + 1 >= beat_len(int'(tempo_sel))) begin
            m_elapsed = 0;
            if (m_beat == LAST_BEAT) begin
`ifdef BEAT_SEQUENCER_LOOP_EN
               m_beat = 0; m_tick = 1;
`else
               m_mode = 3;
`endif
            end else begin
               m_beat = m_beat + 1; m_tick = 1;
            end
         end else m_elapsed = m_elapsed + 1;
      end else if (m_mode == 2) begin
         if (play_de) m_mode = 1;
      end else if (play_de) begin
         m_mode = 1; m_elapsed = 0; m_beat = 0;
      end
   endtask

   // One clock: model follows the sampled inputs, outputs are compared 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check("tick", 32'(beat_tick), 32'(m_tick));
      check("beat", 32'(ibeatNum), 32'(m_beat));
      check("playing", 32'(playing), 32'(m_mode == 1));
      check("done", 32'(done), 32'(m_mode == 3));
      rst = 1'b0; play_de = 1'b0; stop_de = 1'b0;
   endtask

   initial begin
      // Reset and start at cycle 10.
      rst = 1'b1; step();
      check("rst_beat", 32'(ibeatNum), 0);
      check("rst_play", 32'(playing), 0);
      for (int i = 0; i < 9; i++) step();
      play_de = 1'b1; step();
      check("start_playing", 32'(playing), 1);
      for (int i = 1; i <= 12; i++) begin
         step();
         check("start_tick", 32'(beat_tick), (i % 4 == 0) ? 1 : 0);
         if (i % 4 == 0) check("start_beat", 32'(ibeatNum), 32'(i / 4));
      end

      // Pause two cycles after a tick, hold, resume.
      step(); step();
      play_de = 1'b1; step();
      check("pause_playing", 32'(playing), 0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("pause_frozen", 32'(ibeatNum), 3);
      end
      play_de = 1'b1; step();
      check("resume_playing", 32'(playing), 1);
      step();
      check("resume_no_tick", 32'(beat_tick), 0);
      step();
      check("resume_tick", 32'(beat_tick), 1);
      check("resume_beat", 32'(ibeatNum), 4);

      // Fast tempo selected while the prescaler sits at 3.
      step(); step(); step();
      tempo_sel = 2'd1; step();
      check("fast_tick", 32'(beat_tick), 1);
      check("fast_beat", 32'(ibeatNum), 5);
      step();
      check("fast_gap", 32'(beat_tick), 0);
      step();
      check("fast_tick2", 32'(beat_tick), 1);
      check("fast_beat2", 32'(ibeatNum), 6);
      tempo_sel = 2'd0;

      // End of pattern.
      for (int i = 0; i < 40 && ibeatNum != 12'd7; i++) step();
      check("reach_last", 32'(ibeatNum), 7);
`ifdef BEAT_SEQUENCER_LOOP_EN
      for (int i = 0; i < 8 && !beat_tick; i++) step();
      check("wrap_beat", 32'(ibeatNum), 0);
      check("wrap_tick", 32'(beat_tick), 1);
      check("wrap_playing", 32'(playing), 1);
      check("wrap_done", 32'(done), 0);
`else
      for (int i = 0; i < 8 && !done; i++) step();
      check("end_done", 32'(done), 1);
      check("end_beat", 32'(ibeatNum), 7);
      check("end_playing", 32'(playing), 0);
      for (int i = 0; i < 10; i++) begin
         step();
         check("end_quiet", 32'(beat_tick), 0);
      end
      play_de = 1'b1; step();
      check("restart_beat", 32'(ibeatNum), 0);
`endif

      // Simultaneous play and stop at beat 5.
      for (int i = 0; i < 60 && ibeatNum != 12'd5; i++) step();
      check("reach5", 32'(ibeatNum), 5);
      play_de = 1'b1; stop_de = 1'b1; step();
      check("stopwin_beat", 32'(ibeatNum), 0);
      check("stopwin_playing", 32'(playing), 0);

      // Reset while paused at beat 4.
      play_de = 1'b1; step();
      for (int i = 0; i < 40 && ibeatNum != 12'd4; i++) step();
      check("reach4", 32'(ibeatNum), 4);
      step();
      play_de = 1'b1; step();
      step(); step();
      rst = 1'b1; step();
      check("rstp_beat", 32'(ibeatNum), 0);
      check("rstp_playing", 32'(playing), 0);
      check("rstp_done", 32'(done), 0);
      check("rstp_tick", 32'(beat_tick), 0);
      play_de = 1'b1; step();
      check("rstp_restart", 32'(playing), 1);
      for (int i = 0; i < 4; i++) step();
      check("rstp_first_tick", 32'(beat_tick), 1);
      check("rstp_first_beat", 32'(ibeatNum), 1);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         play_de = ($urandom_range(0, 11) == 0);
         stop_de = ($urandom_range(0, 79) == 0);
         rst     = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 29) == 0) tempo_sel = 2'($urandom_range(0, 3));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
